seq_detect_prog_fsm: RTL and testbench

Runtime-programmable serial bit-sequence detector, the parametrised successor to the fixed 4-bit and 6-bit FSM detectors. Detects any pattern of 1..MAX_LEN bits on a 1-bit stream qualified by in_valid, with overlapping or non-overlapping match mode. Emits a one-cycle registered detect pulse and keeps a saturating match counter. Sits in the serial front-end test/debug path of the exercise framework.

---
 rtl/seq_detect_prog_fsm.sv | 147 ++++++++++++++
 tb/tb_seq_detect_prog_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog_fsm.sv
// Runtime-programmable serial sequence detector with a saturating match counter.
// Optional SEQ_DET_CNT_CLR_EN adds a synchronous match-counter clear input (cnt_clr).
module seq_detect_prog_fsm #(
    parameter int                   MAX_LEN     = 16,
    parameter int                   DEF_LEN     = 6,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(16'b0000_0000_0011_0011),
    parameter int                   CNT_W       = 8,
    localparam int                  LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [MAX_LEN-1:0]  cfg_pattern,
    input  logic                cfg_overlap,
    output logic                cfg_err,
`ifdef SEQ_DET_CNT_CLR_EN
    input  logic                cnt_clr,
`endif
    input  logic                in_valid,
    input  logic                a,
    output logic                detected,
    output logic [CNT_W-1:0]    match_count
);

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_CFG_APPLY = 1'b1
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [MAX_LEN-1:0] r_pattern,  w_pattern_nxt;
    logic [LEN_W-1:0]   r_len,      w_len_nxt;
    logic               r_overlap,  w_overlap_nxt;
    logic [MAX_LEN-1:0] r_hist,     w_hist_nxt;
    logic [LEN_W-1:0]   r_fill,     w_fill_nxt;
    logic               r_detected, w_detected_nxt;
    logic               r_cfg_err,  w_cfg_err_nxt;
    logic [CNT_W-1:0]   r_count,    w_count_nxt;

    logic [MAX_LEN-1:0] w_hist_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_inc;
    logic               w_cfg_ok;
    logic               w_match;
    logic               w_hit;
    logic [CNT_W-1:0]   w_count_sat;

    // Match datapath: compare the shifted-in history against the low len pattern bits.
    always_comb begin
        w_hist_shift = {r_hist[MAX_LEN-2:0], a};
        w_fill_inc   = (r_fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : (r_fill + LEN_W'(1));
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_match      = (((w_hist_shift ^ r_pattern) & w_mask) == {MAX_LEN{1'b0}})
                       && (w_fill_inc >= r_len);
        w_cfg_ok     = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(MAX_LEN));
        w_count_sat  = (r_count == {CNT_W{1'b1}}) ? r_count : (r_count + CNT_W'(1));
    end

    // Control FSM next-state and register next values.
    always_comb begin
        w_state_nxt    = r_state;
        w_pattern_nxt  = r_pattern;
        w_len_nxt      = r_len;
        w_overlap_nxt  = r_overlap;
        w_hist_nxt     = r_hist;
        w_fill_nxt     = r_fill;
        w_detected_nxt = 1'b0;
        w_cfg_err_nxt  = 1'b0;
        w_count_nxt    = r_count;
        w_hit          = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (cfg_valid && w_cfg_ok) begin
                    // Accepted config wins over any stream bit offered in the same cycle.
                    w_pattern_nxt = cfg_pattern;
                    w_len_nxt     = cfg_len;
                    w_overlap_nxt = cfg_overlap;
                    w_state_nxt   = ST_CFG_APPLY;
                end else begin
                    w_cfg_err_nxt = cfg_valid;
                    if (in_valid) begin
                        w_hit          = w_match;
                        w_hist_nxt     = w_hist_shift;
                        w_detected_nxt = w_match;
                        if (w_match) begin
                            w_count_nxt = w_count_sat;
                            w_fill_nxt  = r_overlap ? w_fill_inc : {LEN_W{1'b0}};
                        end else begin
                            w_fill_nxt  = w_fill_inc;
                        end
                    end else begin
                        w_hist_nxt = r_hist;
                    end
                end
            end
            ST_CFG_APPLY: begin
                w_hist_nxt  = {MAX_LEN{1'b0}};
                w_fill_nxt  = {LEN_W{1'b0}};
                w_count_nxt = {CNT_W{1'b0}};
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
`ifdef SEQ_DET_CNT_CLR_EN
        if (cnt_clr) begin
            w_count_nxt = w_hit ? CNT_W'(1) : {CNT_W{1'b0}};
        end else begin
            w_count_nxt = w_count_nxt;
        end
`endif
    end

    // State and datapath registers, default configuration on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pattern  <= DEF_PATTERN;
            r_len      <= LEN_W'(DEF_LEN);
            r_overlap  <= 1'b1;
            r_hist     <= {MAX_LEN{1'b0}};
            r_fill     <= {LEN_W{1'b0}};
            r_detected <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_count    <= {CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_pattern  <= w_pattern_nxt;
            r_len      <= w_len_nxt;
            r_overlap  <= w_overlap_nxt;
            r_hist     <= w_hist_nxt;
            r_fill     <= w_fill_nxt;
            r_detected <= w_detected_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
            r_count    <= w_count_nxt;
        end
    end

    assign detected    = r_detected;
    assign cfg_err     = r_cfg_err;
    assign match_count = r_count;

endmodule

// File: tb/tb_seq_detect_prog_fsm.sv
// Scoreboard bench for seq_detect_prog_fsm: drivers queue expected pulses, a monitor checks them.
module tb_seq_detect_prog_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [4:0]  cfg_len;
    logic [15:0] cfg_pattern;
    logic        cfg_overlap;
    logic        in_valid, a;
    logic        cfg_err, detected;
    logic [7:0]  match_count;
    logic        in_valid2, a2;
    logic        cfg_err2, detected2;
    logic [1:0]  match_count2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct { int t; int n; } exp_t;
    exp_t det_q[$];
    exp_t det2_q[$];
    int   err_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detect_prog_fsm u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_len(cfg_len),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
`ifdef SEQ_DET_CNT_CLR_EN
        .cnt_clr(1'b0),
`endif
        .in_valid(in_valid), .a(a), .detected(detected), .match_count(match_count)
    );

    seq_detect_prog_fsm #(.CNT_W(2), .DEF_LEN(1), .DEF_PATTERN(16'h0001)) u_dut2 (
        .clk(clk), .rst(rst), .cfg_valid(1'b0), .cfg_len(5'd0),
        .cfg_pattern(16'h0000), .cfg_overlap(1'b0), .cfg_err(cfg_err2),
`ifdef SEQ_DET_CNT_CLR_EN
        .cnt_clr(1'b0),
`endif
        .in_valid(in_valid2), .a(a2), .detected(detected2), .match_count(match_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (!rst) begin
            while (det_q.size() > 0 && det_q[0].t < cyc) begin
                flag("det_missed");
                void'(det_q.pop_front());
            end
            if (detected) begin
                if (det_q.size() == 0) begin
                    flag("det_unexpected");
                end else begin
                    check("det_cycle", cyc, det_q[0].t);
                    check("det_count", match_count, det_q[0].n);
                    void'(det_q.pop_front());
                end
            end
            while (err_q.size() > 0 && err_q[0] < cyc) begin
                flag("err_missed");
                void'(err_q.pop_front());
            end
            if (cfg_err) begin
                if (err_q.size() == 0) begin
                    flag("err_unexpected");
                end else begin
                    check("err_cycle", cyc, err_q[0]);
                    void'(err_q.pop_front());
                end
            end
            while (det2_q.size() > 0 && det2_q[0].t < cyc) begin
                flag("det2_missed");
                void'(det2_q.pop_front());
            end
            if (detected2) begin
                if (det2_q.size() == 0) begin
                    flag("det2_unexpected");
                end else begin
                    check("det2_cycle", cyc, det2_q[0].t);
                    check("det2_count", match_count2, det2_q[0].n);
                    void'(det2_q.pop_front());
                end
            end
            if (cfg_err2) flag("err2_unexpected");
        end
    end

    task automatic send(input logic b, input logic exp_det, input int cnt,
                        input logic bad = 1'b0, input logic [4:0] blen = 5'd0);
        @(negedge clk);
        a = b;
        in_valid = 1'b1;
        cfg_valid = bad;
        cfg_len = blen;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_valid = 1'b0;
        if (exp_det) det_q.push_back('{t: cyc, n: cnt});
        if (bad) err_q.push_back(cyc);
    endtask

    task automatic send2(input logic b, input int cnt);
        @(negedge clk);
        a2 = b;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        det2_q.push_back('{t: cyc, n: cnt});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [4:0] len, input logic [15:0] pat, input logic ovl);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_len = len;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        idle(1);
    endtask

    // bits/flags are MSB-first: bit n-1 is the first one sent.
    task automatic run_stream(input logic [31:0] bits, input logic [31:0] flags,
                              input int n, input int gap, input int cnt0);
        int cnt = cnt0;
        for (int i = 0; i < n; i++) begin
            if (flags[n-1-i]) cnt++;
            send(bits[n-1-i], flags[n-1-i], cnt);
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_len = 5'd0; cfg_pattern = 16'h0000; cfg_overlap = 1'b0;
        in_valid = 1'b0; a = 1'b0; in_valid2 = 1'b0; a2 = 1'b0;
        idle(2);
        check("rst_detected", detected, 32'd0);
        check("rst_cfg_err", cfg_err, 32'd0);
        check("rst_count", match_count, 32'd0);
        check("rst_count2", match_count2, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Default 110011, overlapping: pulses after bits 5, 9, 13.
        run_stream(32'b11001100110011, 32'b00000100010001, 14, 0, 0);
        idle(2);
        check("t1_count", match_count, 32'd3);

        // Same pattern, non-overlapping: pulses after bits 5 and 13.
        configure(5'd6, 16'h0033, 1'b0);
        check("t2_cleared", match_count, 32'd0);
        run_stream(32'b11001100110011, 32'b00000100000001, 14, 0, 0);
        idle(2);
        check("t2_count", match_count, 32'd2);

        // len 4, pattern 1010 with garbage upper bits, gapped stream.
        configure(5'd4, 16'hA5FA, 1'b1);
        run_stream(32'b101010, 32'b000101, 6, 2, 0);
        idle(2);
        check("t3_count", match_count, 32'd2);

        // Reset mid-stream after 11001 under the 1010 config.
        run_stream(32'b11001, 32'b00000, 5, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_detected", detected, 32'd0);
        check("mid_rst_count", match_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_stream(32'b1110011, 32'b0000001, 7, 0, 0);
        idle(2);
        check("t6_count", match_count, 32'd1);

        // Rejected configs (len 0, len 17) mid-stream; detection continues.
        send(1'b1, 1'b0, 0);
        send(1'b1, 1'b0, 0);
        send(1'b0, 1'b0, 0);
        send(1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 0, 1'b1, 5'd0);
        send(1'b1, 1'b1, 2);
        send(1'b0, 1'b0, 0, 1'b1, 5'd17);
        send(1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 0);
        send(1'b1, 1'b1, 3);
        idle(2);
        check("t5_count", match_count, 32'd3);

        // Two-bit counter, len 1 pattern 1: counter saturates at 3.
        send2(1'b1, 1);
        send2(1'b1, 2);
        send2(1'b1, 3);
        send2(1'b1, 3);
        send2(1'b1, 3);
        idle(3);
        check("t4_count2", match_count2, 32'd3);
        check("q_det_empty", det_q.size(), 32'd0);
        check("q_err_empty", err_q.size(), 32'd0);
        check("q_det2_empty", det2_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
